// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one registered ALU between NREQ requesters.
// Optional illegal-op screening is enabled by defining ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
    parameter int NREQ    = 2,
    parameter int ALU_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [4*NREQ-1:0]  req_op,
    input  logic [32*NREQ-1:0] req_lhs,
    input  logic [32*NREQ-1:0] req_rhs,
    output logic [NREQ-1:0]    resp_valid,
    input  logic [NREQ-1:0]    resp_ready,
    output logic [31:0]        resp_res,
    output logic [3:0]         resp_flags,
    output logic               resp_err,
    output logic               busy,
    output logic [3:0]         alu_op,
    output logic [31:0]        alu_lhs,
    output logic [31:0]        alu_rhs,
    input  logic [31:0]        alu_res,
    input  logic [3:0]         alu_flags
);

    localparam int DATA_W = 32;
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW     = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

    state_t              state;
    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      id;
    logic [CW-1:0]       cnt;

    logic                gnt_any;
    logic [IDW-1:0]      gnt_idx;
    logic [IDW-1:0]      cand;
    logic [3:0]          gnt_op;
    logic [DATA_W-1:0]   gnt_lhs;
    logic [DATA_W-1:0]   gnt_rhs;
    logic                gnt_illegal;

    function automatic logic [IDW-1:0] wrap_inc(input logic [IDW-1:0] p);
        return (p == IDW'(NREQ - 1)) ? '0 : p + IDW'(1);
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Scan starts one past the last winner so the previous grantee has lowest priority.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = wrap_inc(ptr);
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && req_valid[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
            cand = wrap_inc(cand);
        end
    end

    always_comb begin
        gnt_op  = '0;
        gnt_lhs = '0;
        gnt_rhs = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                gnt_op  = req_op[4*i +: 4];
                gnt_lhs = req_lhs[DATA_W*i +: DATA_W];
                gnt_rhs = req_rhs[DATA_W*i +: DATA_W];
            end
        end
    end

`ifdef ALU_ARB_OPCHECK_EN
    assign gnt_illegal = (gnt_op >= 4'b1101);
`else
    assign gnt_illegal = 1'b0;
`endif

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_any)
            req_ready[gnt_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= IDW'(NREQ - 1);
            id         <= '0;
            cnt        <= '0;
            resp_valid <= '0;
            resp_res   <= '0;
            resp_flags <= '0;
            resp_err   <= 1'b0;
            alu_op     <= '0;
            alu_lhs    <= '0;
            alu_rhs    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_any) begin
                        id       <= gnt_idx;
                        ptr      <= gnt_idx;
                        resp_err <= gnt_illegal;
                        if (gnt_illegal) begin
                            // Illegal ops never reach the ALU; answer immediately.
                            resp_res   <= '0;
                            resp_flags <= '0;
                            resp_valid <= onehot(gnt_idx);
                            state      <= RESP;
                        end else begin
                            alu_op  <= gnt_op;
                            alu_lhs <= gnt_lhs;
                            alu_rhs <= gnt_rhs;
                            state   <= EXEC;
                        end
                    end
                end
                EXEC: begin
                    cnt   <= CW'(ALU_LAT - 1);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        resp_res   <= alu_res;
                        resp_flags <= alu_flags;
                        resp_valid <= onehot(id);
                        state      <= RESP;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                RESP: begin
                    if (resp_ready[id]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural arbiter model plus directed vectors, with a
// second ALU_LAT=3 instance for the longer-latency path.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int LAT  = 1;
    localparam int LATB = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req_valid, req_ready, resp_valid, resp_ready;
    logic [4*NREQ-1:0]  req_op;
    logic [32*NREQ-1:0] req_lhs, req_rhs;
    logic [31:0]        resp_res, alu_lhs, alu_rhs, alu_res;
    logic [3:0]         resp_flags, alu_op, alu_flags;
    logic               resp_err, busy;

    logic [NREQ-1:0]    b_req_valid, b_req_ready, b_resp_valid, b_resp_ready;
    logic [4*NREQ-1:0]  b_req_op;
    logic [32*NREQ-1:0] b_req_lhs, b_req_rhs;
    logic [31:0]        b_resp_res, b_alu_lhs, b_alu_rhs, b_alu_res;
    logic [3:0]         b_resp_flags, b_alu_op, b_alu_flags;
    logic               b_resp_err, b_busy;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(LAT)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_lhs(req_lhs), .req_rhs(req_rhs),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_res(resp_res),
        .resp_flags(resp_flags), .resp_err(resp_err), .busy(busy),
        .alu_op(alu_op), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_res(alu_res), .alu_flags(alu_flags)
    );

    alu_arbiter #(.NREQ(NREQ), .ALU_LAT(LATB)) u_dut3 (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_op(b_req_op), .req_lhs(b_req_lhs), .req_rhs(b_req_rhs),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_res(b_resp_res),
        .resp_flags(b_resp_flags), .resp_err(b_resp_err), .busy(b_busy),
        .alu_op(b_alu_op), .alu_lhs(b_alu_lhs), .alu_rhs(b_alu_rhs),
        .alu_res(b_alu_res), .alu_flags(b_alu_flags)
    );

    // Reference ALU: add (0000), sub (1000), xor otherwise; flags {zero,sign,carry,ovf}.
    function automatic logic [35:0] alu_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] w;
        logic [31:0] r;
        logic        c, v;
        c = 1'b0;
        v = 1'b0;
        case (op)
            4'b0000: begin
                w = {1'b0, a} + {1'b0, b};
                r = w[31:0];
                c = w[32];
                v = ~(a[31] ^ b[31]) & (a[31] ^ r[31]);
            end
            4'b1000: begin
                r = a - b;
                c = (a < b);
                v = (a[31] ^ b[31]) & (a[31] ^ r[31]);
            end
            default: r = a ^ b;
        endcase
        return {(r == 32'd0), r[31], c, v, r};
    endfunction

    logic [35:0] apipe [LAT];
    logic [35:0] bpipe [LATB];
    always @(posedge clk) begin
        apipe[0] <= alu_calc(alu_op, alu_lhs, alu_rhs);
        for (int s = 1; s < LAT; s++) apipe[s] <= apipe[s-1];
        bpipe[0] <= alu_calc(b_alu_op, b_alu_lhs, b_alu_rhs);
        for (int s = 1; s < LATB; s++) bpipe[s] <= bpipe[s-1];
    end
    assign alu_res     = apipe[LAT-1][31:0];
    assign alu_flags   = apipe[LAT-1][35:32];
    assign b_alu_res   = bpipe[LATB-1][31:0];
    assign b_alu_flags = bpipe[LATB-1][35:32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Round-robin pick: first valid requester after the last winner, modulo NREQ.
    function automatic int pick(input int p, input logic [NREQ-1:0] v);
        for (int k = 1; k <= NREQ; k++)
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        return -1;
    endfunction

    // Transaction-level model: busy window, cycles until response, captured values.
    bit          m_busy;
    int          m_ptr, m_id, m_wait;
    logic [31:0] m_res, m_pend_res, m_aop, m_alhs, m_arhs;
    logic [3:0]  m_flags, m_pend_flags;
    logic        m_err;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_ptr = NREQ - 1; m_id = 0; m_wait = 0;
            m_res = 0; m_flags = 0; m_err = 0; m_aop = 0; m_alhs = 0; m_arhs = 0;
        end else if (!m_busy) begin
            int g;
            logic [3:0]  op;
            logic [31:0] a, b;
            g = pick(m_ptr, req_valid);
            if (g >= 0) begin
                op = req_op[4*g +: 4];
                a  = req_lhs[32*g +: 32];
                b  = req_rhs[32*g +: 32];
                m_id = g; m_ptr = g; m_busy = 1; m_err = 0;
`ifdef ALU_ARB_OPCHECK_EN
                if (op >= 4'd13) begin
                    m_err = 1; m_wait = 0; m_res = 0; m_flags = 0;
                end else
`endif
                begin
                    m_aop = {28'd0, op}; m_alhs = a; m_arhs = b;
                    {m_pend_flags, m_pend_res} = alu_calc(op, a, b);
                    m_wait = LAT + 1;
                end
            end
        end else if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
                m_res = m_pend_res;
                m_flags = m_pend_flags;
            end
        end else if (resp_ready[m_id]) begin
            m_busy = 0;
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            int g;
            logic [NREQ-1:0] er, ev;
            g  = pick(m_ptr, req_valid);
            er = '0;
            ev = '0;
            if (!m_busy && g >= 0) er[g] = 1'b1;
            if (m_busy && m_wait == 0) ev[m_id] = 1'b1;
            chk("m.req_ready", 32'(req_ready), 32'(er));
            chk("m.busy", 32'(busy), 32'(m_busy));
            chk("m.resp_valid", 32'(resp_valid), 32'(ev));
            chk("m.resp_res", resp_res, m_res);
            chk("m.resp_flags", 32'(resp_flags), 32'(m_flags));
            chk("m.resp_err", 32'(resp_err), 32'(m_err));
            chk("m.alu_op", 32'(alu_op), m_aop);
            chk("m.alu_lhs", alu_lhs, m_alhs);
            chk("m.alu_rhs", alu_rhs, m_arhs);
        end
    end

    task automatic issue(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit ok;
        ok = 0;
        req_valid[i] = 1'b1;
        req_op[4*i +: 4] = op;
        req_lhs[32*i +: 32] = a;
        req_rhs[32*i +: 32] = b;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready[i]) begin ok = 1; break; end
        end
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        chk("handshake", 32'(ok), 32'd1);
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (resp_valid != '0) begin lat = n; break; end
        end
    endtask

    task automatic release_resp(input int i);
        resp_ready[i] = 1'b1;
        @(posedge clk); #1;
        resp_ready = '0;
    endtask

    typedef struct { logic [3:0] op; logic [31:0] a, b, exp; } vec_t;
    vec_t tbl [4] = '{
        '{4'b0000, 32'hFFFF_FFFF, 32'd1, 32'h0000_0000},
        '{4'b1000, 32'd0,         32'd1, 32'hFFFF_FFFF},
        '{4'b0011, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_FF00},
        '{4'b0000, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000}
    };

    initial begin
        int lat, k;
        logic [NREQ-1:0] got_v [4];
        logic [31:0]     got_r [4];
        bit idle_ok;

        rst = 1'b1;
        req_valid = '0; req_op = '0; req_lhs = '0; req_rhs = '0; resp_ready = '0;
        b_req_valid = '0; b_req_op = '0; b_req_lhs = '0; b_req_rhs = '0; b_resp_ready = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.resp_valid", 32'(resp_valid), 32'd0);
        chk("rst.req_ready", 32'(req_ready), 32'd0);
        chk("rst.resp_res", resp_res, 32'd0);
        chk("rst.alu_op", 32'(alu_op), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Single add 5+7 on requester 0.
        issue(0, 4'b0000, 32'd5, 32'd7);
        wait_resp(lat);
        chk("add.latency", 32'(lat), 32'd3);
        chk("add.resp_valid", 32'(resp_valid), 32'b01);
        chk("add.resp_res", resp_res, 32'd12);
        chk("add.zero_flag", 32'(resp_flags[3]), 32'd0);

        // Backpressure, with a competing request and a stray resp_ready on the other bit.
        @(posedge clk); #1;
        resp_ready = 2'b10;
        req_valid[1] = 1'b1;
        req_op[7:4] = 4'b1000; req_lhs[63:32] = 32'd10; req_rhs[63:32] = 32'd3;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("bp.resp_res", resp_res, 32'd12);
            chk("bp.resp_flags", 32'(resp_flags), 32'd0);
            chk("bp.busy", 32'(busy), 32'd1);
            chk("bp.req_ready", 32'(req_ready), 32'd0);
            chk("bp.resp_valid", 32'(resp_valid), 32'b01);
        end
        @(posedge clk); #1;
        release_resp(0);
        // Requester 1 is granted in this IDLE cycle; reset it while in WAIT.
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        @(posedge clk); #1;
        chk("rw.busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rw.busy", 32'(busy), 32'd0);
        chk("rw.resp_valid", 32'(resp_valid), 32'd0);
        chk("rw.resp_res", resp_res, 32'd0);
        chk("rw.resp_flags", 32'(resp_flags), 32'd0);
        chk("rw.alu_op", 32'(alu_op), 32'd0);
        chk("rw.alu_lhs", alu_lhs, 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            chk("rw.no_resp", 32'(resp_valid), 32'd0);
        end

        // Round robin with both requesters valid continuously.
        @(posedge clk); #1;
        req_op = {4'b0000, 4'b0000};
        req_lhs = {32'd2, 32'd1};
        req_rhs = {32'd2, 32'd1};
        resp_ready = 2'b11;
        req_valid = 2'b11;
        k = 0;
        for (int n = 0; n < 80 && k < 4; n++) begin
            @(negedge clk);
            if (resp_valid != '0) begin
                got_v[k] = resp_valid;
                got_r[k] = resp_res;
                k++;
            end
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("rr.count", 32'(k), 32'd4);
        for (int j = 0; j < 4; j++) begin
            if (j < k) begin
                chk("rr.resp_valid", 32'(got_v[j]), (j % 2 == 0) ? 32'b01 : 32'b10);
                chk("rr.resp_res", got_r[j], (j % 2 == 0) ? 32'd2 : 32'd4);
            end
        end
        idle_ok = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (!busy) begin idle_ok = 1; break; end
        end
        chk("rr.drain", 32'(idle_ok), 32'd1);
        @(posedge clk); #1;
        resp_ready = '0;

        // Directed operand table, alternating requesters.
        for (int j = 0; j < 4; j++) begin
            issue(j % 2, tbl[j].op, tbl[j].a, tbl[j].b);
            wait_resp(lat);
            chk("tbl.latency", 32'(lat), 32'd3);
            chk("tbl.resp_res", resp_res, tbl[j].exp);
            release_resp(j % 2);
        end

`ifdef ALU_ARB_OPCHECK_EN
        issue(1, 4'b1111, 32'd1, 32'd2);
        wait_resp(lat);
        chk("ill.latency", 32'(lat), 32'd1);
        chk("ill.resp_valid", 32'(resp_valid), 32'b10);
        chk("ill.resp_err", 32'(resp_err), 32'd1);
        chk("ill.resp_res", resp_res, 32'd0);
        chk("ill.alu_op", 32'(alu_op), 32'd0);
        release_resp(1);
        issue(0, 4'b0000, 32'd1, 32'd1);
        wait_resp(lat);
        chk("legal.resp_err", 32'(resp_err), 32'd0);
        release_resp(0);
`endif

        // ALU_LAT=3 instance: 3-3 via sub.
        b_req_op[3:0] = 4'b1000; b_req_lhs[31:0] = 32'd3; b_req_rhs[31:0] = 32'd3;
        b_req_valid = 2'b01;
        @(negedge clk);
        chk("lat3.req_ready", 32'(b_req_ready), 32'b01);
        @(posedge clk); #1;
        b_req_valid = '0;
        lat = 0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (b_resp_valid != '0) begin lat = n; break; end
        end
        chk("lat3.latency", 32'(lat), 32'd5);
        chk("lat3.resp_valid", 32'(b_resp_valid), 32'b01);
        chk("lat3.resp_res", b_resp_res, 32'd0);
        chk("lat3.zero_flag", 32'(b_resp_flags[3]), 32'd1);
        b_resp_ready = 2'b01;
        @(posedge clk); #1;
        b_resp_ready = '0;
        @(negedge clk);
        chk("lat3.idle", 32'(b_busy), 32'd0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
